// File: rtl/ebus_pkg.sv
// Shared definitions for the EBUS transfer controller: FSM state encoding,
// EBUS function codes, bus field widths and default timing parameters.
package ebus_pkg;

  localparam int unsigned FUNC_W  = 3;
  localparam int unsigned DEV_W   = 7;
  localparam int unsigned DATA_W  = 36;
  localparam int unsigned SETUP_W = 3;
  localparam int unsigned TMO_W   = 8;

  localparam int unsigned TIMEOUT_DEF   = 255;
  localparam int unsigned SETUP_CYC_DEF = 2;

  // EBUS function codes; zero is left unused so an idle bus reads as "no function"
  localparam logic [FUNC_W-1:0] FN_CONO     = 3'd1;
  localparam logic [FUNC_W-1:0] FN_CONI     = 3'd2;
  localparam logic [FUNC_W-1:0] FN_DATAO    = 3'd3;
  localparam logic [FUNC_W-1:0] FN_DATAI    = 3'd4;
  localparam logic [FUNC_W-1:0] FN_PI_SERVE = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_GNT = 3'd1,
    ST_SETUP    = 3'd2,
    ST_DEMAND   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_DONE     = 3'd5
  } ebus_state_e;

  // True for functions that return data from the device
  function automatic logic fn_is_read(input logic [FUNC_W-1:0] f);
    return (f == FN_CONI) || (f == FN_DATAI);
  endfunction

endpackage

// File: rtl/ebus_xfer_ctl_if.sv
// EBUS transfer controller signal bundle.
//   master : the controller (consumes microcode/device inputs, drives the bus)
//   slave  : the environment (microcode, arbiter and device side)
interface ebus_xfer_ctl_if;
  import ebus_pkg::*;

  // microcode / arbiter side
  logic                CON_COND_EBUS_CTL;
  logic                CON_IO_LEGAL;
  logic                CON_EBUS_GRANT;
  logic                CON_EBUS_REL;
  logic [FUNC_W-1:0]   func_in;
  logic [DEV_W-1:0]    dev_in;
  logic [DATA_W-1:0]   data_in;
  logic                func_is_read;
  // device side
  logic                EBUS_XFER_IN;
  logic [DATA_W-1:0]   EBUS_D_IN;
  // controller outputs
  logic                EBUS_REQ;
  logic [FUNC_W-1:0]   EBUS_F;
  logic [DEV_W-1:0]    EBUS_CS;
  logic [DATA_W-1:0]   EBUS_D_OUT;
  logic                EBUS_D_OE;
  logic                EBUS_DEMAND;
  logic [DATA_W-1:0]   rd_data;
  logic                xfer_done;
  logic                xfer_timeout;
  logic                busy;

  modport master (
    input  CON_COND_EBUS_CTL, CON_IO_LEGAL, CON_EBUS_GRANT, CON_EBUS_REL,
    input  func_in, dev_in, data_in, func_is_read, EBUS_XFER_IN, EBUS_D_IN,
    output EBUS_REQ, EBUS_F, EBUS_CS, EBUS_D_OUT, EBUS_D_OE, EBUS_DEMAND,
    output rd_data, xfer_done, xfer_timeout, busy
  );

  modport slave (
    output CON_COND_EBUS_CTL, CON_IO_LEGAL, CON_EBUS_GRANT, CON_EBUS_REL,
    output func_in, dev_in, data_in, func_is_read, EBUS_XFER_IN, EBUS_D_IN,
    input  EBUS_REQ, EBUS_F, EBUS_CS, EBUS_D_OUT, EBUS_D_OE, EBUS_DEMAND,
    input  rd_data, xfer_done, xfer_timeout, busy
  );

endinterface

// File: rtl/ebus_timeout_ctr.sv
// Demand timeout counter.
//   clk, rst_n  : clock, async active-low reset (count clears to 0)
//   load_i      : load load_val_i (wins over decrement)
//   dec_i       : decrement by one, saturating at 0
//   zero_c_o    : combinational; this clock's decrement takes the count to 0
module ebus_timeout_ctr
  import ebus_pkg::*;
#(
  parameter int unsigned WIDTH = TMO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_c_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load has priority, decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c_o = dec_i && !load_i && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/ebus_xfer_ctl.sv
// EBOX-side EBUS transfer controller: on a legal microcode strobe it latches
// the function/device/data, requests the bus, presents address and function
// for SETUP_CYC clocks, raises DEMAND until the device acknowledges (or the
// demand times out), waits for the acknowledge to drop, then reports.
//   clk, rst_n : clock, async active-low reset
//   bus        : ebus_xfer_ctl_if.master (microcode strobe/grant/release,
//                device XFER/data in; REQ/F/CS/D/DEMAND out; rd_data,
//                xfer_done, xfer_timeout, busy status). All outputs registered.
module ebus_xfer_ctl
  import ebus_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned SETUP_CYC = SETUP_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  ebus_xfer_ctl_if.master bus
);

  ebus_state_e         state_q, state_d;
  logic [SETUP_W-1:0]  setup_cnt_q, setup_cnt_d;

  logic [FUNC_W-1:0]   func_q, func_d;
  logic [DEV_W-1:0]    dev_q, dev_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                is_read_q, is_read_d;

  logic                req_q, req_d;
  logic [FUNC_W-1:0]   f_q, f_d;
  logic [DEV_W-1:0]    cs_q, cs_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                oe_q, oe_d;
  logic                demand_q, demand_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                done_q, done_d;
  logic                tmo_q, tmo_d;
  logic                busy_q, busy_d;

  logic                tmo_load;
  logic                tmo_dec;
  logic                tmo_zero_c;
  logic                bus_act;

  ebus_timeout_ctr #(
    .WIDTH (TMO_W)
  ) u_tmo_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmo_load),
    .load_val_i (TMO_W'(TIMEOUT)),
    .dec_i      (tmo_dec),
    .zero_c_o   (tmo_zero_c)
  );

  // Next state, latched transaction, and registered-output values
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    func_d      = func_q;
    dev_d       = dev_q;
    data_d      = data_q;
    is_read_d   = is_read_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    tmo_d       = 1'b0;
    tmo_load    = 1'b0;
    tmo_dec     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.CON_COND_EBUS_CTL && bus.CON_IO_LEGAL) begin
          state_d   = ST_WAIT_GNT;
          func_d    = bus.func_in;
          dev_d     = bus.dev_in;
          data_d    = bus.data_in;
          is_read_d = bus.func_is_read;
        end
      end
      ST_WAIT_GNT: begin
        if (bus.CON_EBUS_GRANT) begin
          state_d     = ST_SETUP;
          setup_cnt_d = SETUP_W'(SETUP_CYC);
        end
      end
      ST_SETUP: begin
        // grant is no longer looked at; only release aborts from here on
        if (setup_cnt_q <= SETUP_W'(1)) begin
          state_d     = ST_DEMAND;
          setup_cnt_d = '0;
          tmo_load    = 1'b1;
        end else begin
          setup_cnt_d = setup_cnt_q - SETUP_W'(1);
        end
      end
      ST_DEMAND: begin
        // acknowledge is tested first so it wins over an expiring count
        if (bus.EBUS_XFER_IN) begin
          state_d = ST_HOLD;
          if (is_read_q) begin
            rd_data_d = bus.EBUS_D_IN;
          end
        end else begin
          tmo_dec = 1'b1;
          if (tmo_zero_c) begin
            state_d   = ST_DONE;
            tmo_d     = 1'b1;
            rd_data_d = '0;
          end
        end
      end
      ST_HOLD: begin
        if (!bus.EBUS_XFER_IN) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Release overrides every transition and suppresses completion pulses
    if (bus.CON_EBUS_REL && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      setup_cnt_d = '0;
      rd_data_d   = rd_data_q;
      done_d      = 1'b0;
      tmo_d       = 1'b0;
      tmo_load    = 1'b0;
      tmo_dec     = 1'b0;
    end

    // Bus outputs are decoded from the next state so they register in step with it
    bus_act  = (state_d == ST_SETUP) || (state_d == ST_DEMAND) || (state_d == ST_HOLD);
    req_d    = bus_act || (state_d == ST_WAIT_GNT);
    f_d      = bus_act ? func_d : '0;
    cs_d     = bus_act ? dev_d : '0;
    oe_d     = bus_act && !is_read_d;
    dout_d   = oe_d ? data_d : '0;
    demand_d = (state_d == ST_DEMAND);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= '0;
      func_q      <= '0;
      dev_q       <= '0;
      data_q      <= '0;
      is_read_q   <= 1'b0;
      req_q       <= 1'b0;
      f_q         <= '0;
      cs_q        <= '0;
      dout_q      <= '0;
      oe_q        <= 1'b0;
      demand_q    <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      func_q      <= func_d;
      dev_q       <= dev_d;
      data_q      <= data_d;
      is_read_q   <= is_read_d;
      req_q       <= req_d;
      f_q         <= f_d;
      cs_q        <= cs_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      demand_q    <= demand_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.EBUS_REQ     = req_q;
  assign bus.EBUS_F       = f_q;
  assign bus.EBUS_CS      = cs_q;
  assign bus.EBUS_D_OUT   = dout_q;
  assign bus.EBUS_D_OE    = oe_q;
  assign bus.EBUS_DEMAND  = demand_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.xfer_done    = done_q;
  assign bus.xfer_timeout = tmo_q;
  assign bus.busy         = busy_q;

endmodule
